ctrl_seq: RTL
=============

Name: ctrl_seq

Overview:
- Sequential, parametrised control unit driving program_counter (fetch unit) and the compare-flag path.
- Holds a bank of NUM_FLAGS compare flags written by compare ops and selected by branch ops.
- Adds a post-branch flush window (BR_DELAY cycles) and a sticky HALT state.

Parameters:
- INSTR_W, 9, instruction width.
- OP_W, 3, opcode width; opcode = Instruction[INSTR_W-1 -: OP_W].
- NUM_FLAGS, 2, number of flag registers (1..8).
- BR_DELAY, 1, flush cycles after a taken branch (0..3).

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- Instruction  in  INSTR_W  machine code from instrROM.
- instr_valid  in  1  Instruction is meaningful this cycle.
- FLAG_IN  in  1  ALU compare result.
- branch_en  out  1  take branch this cycle (combinational).
- flag_write  out  1  a compare flag is written at the next edge (combinational).
- flush  out  1  fetch must discard the current instruction.
- halt  out  1  processor halted.
- flags_q  out  NUM_FLAGS  registered flag bank.

Behaviour:
- Decoded fields:
  - FSEL_W = max(1, $clog2(NUM_FLAGS)).
  - fsel = Instruction[FSEL_W-1:0].
  - "act" = instr_valid & state==RUN.
- States: RUN, FLUSH, HALT. Reset enters RUN; no other reset values exist beyond the ones below.
- Reset values: flags_q=0, flush counter=0, flush=0, halt=0. branch_en and flag_write are 0 during reset.
- flag_write:
  - Asserted = act & (op==opCEQ | op==opCLT) & fsel<NUM_FLAGS.
  - Next edge: flags_q[fsel] <= FLAG_IN.
  - fsel out of range: no write, flag_write=0.
- branch_en:
  - Asserted = act & op==opOTHER & fsel<NUM_FLAGS & flags_q[fsel].
  - Uses the registered flag only, with no bypass. A compare in cycle N is visible to a branch in cycle N+1.
- Taken branch in RUN:
  - BR_DELAY>0: next state FLUSH, counter <= BR_DELAY-1.
  - BR_DELAY==0: stays RUN.
- FLUSH:
  - flush=1.
  - branch_en=0 and flag_write=0 regardless of input; instructions are ignored.
  - Counter decrements each cycle; at 0 returns to RUN.
  - Length is exactly BR_DELAY cycles.
- act & op==opHALT:
  - Next state HALT.
  - HALT: halt=1, flush=0, branch_en=0, flag_write=0, flags_q frozen.
  - Only Reset exits HALT.
- Simultaneous events:
  - An instruction is either a compare or a branch, never both.
  - A halt encoding takes priority over nothing else since opcodes are exclusive.
- Reset mid-FLUSH or in HALT: returns to RUN with flags cleared at that edge.
- instr_valid=0 in RUN: no writes, no branch, state held.

Optional Feature:
- Macro: CTRL_BRCOUNT_EN.
- Defined:
  - Extra port br_count out 16: count of taken branches.
  - Increments on each cycle branch_en=1 and saturates at 16'hFFFF.
  - Reset value 0; frozen in HALT.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- definitions package gains:
  - opHALT.
  - ctrl_state_t enum {RUN, FLUSH, HALT}.
  - OP_W default constant.
- Existing opCEQ, opCLT and opOTHER stay in definitions.
- Sub-module ctrl_flag_bank:
  - Inputs: Clk, Reset, we, sel, d.
  - Output: q[NUM_FLAGS].
  - Parametrised on NUM_FLAGS; instantiated once.

Test Plan:
- Reset=1 for 2 cycles with valid branch on Instruction -> flags_q=0, branch_en=0, flush=0, halt=0.
- CEQ fsel=1 with FLAG_IN=1, then branch fsel=1 next cycle -> flag_write=1 then flags_q=2'b10; branch_en=1 in the branch cycle. Branch fsel=0 -> branch_en=0.
- BR_DELAY=2, taken branch then valid CLT for 2 cycles -> flush=1 for exactly 2 cycles, flag_write=0, flags_q unchanged; RUN on cycle 3. Repeat with BR_DELAY=0 -> flush never 1.
- opHALT followed by compares/branches for 5 cycles -> halt=1 held, flags frozen, branch_en=0. Reset -> halt=0 next cycle.
- NUM_FLAGS=3, compare fsel=3 -> flag_write=0, flags_q unchanged. Reset asserted mid-FLUSH -> state RUN, flush=0 next cycle.
- CTRL_BRCOUNT_EN: 3 taken branches with BR_DELAY=0 -> br_count=3. Preload near 16'hFFFF -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the control sequencer: opcodes, FSM state type and
// the flag-select width helper.
package ctrl_seq_pkg;

    localparam int INSTR_W_DEF = 9;
    localparam int OP_W_DEF    = 3;

    localparam logic [2:0] opCEQ   = 3'b001;
    localparam logic [2:0] opCLT   = 3'b010;
    localparam logic [2:0] opOTHER = 3'b011;
    localparam logic [2:0] opHALT  = 3'b111;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } ctrl_state_t;

    function automatic int fsel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ctrl_seq_flag_bank.sv
// Bank of single-bit compare flags; one flag written per cycle when we is high.
module ctrl_flag_bank
    import ctrl_seq_pkg::*;
#(
    parameter int NUM_FLAGS = 2,
    parameter int SEL_W     = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 we,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 d,
    output logic [NUM_FLAGS-1:0] q
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q <= '0;
        end else begin
            for (int i = 0; i < NUM_FLAGS; i++) begin
                if (we && (int'(sel) == i)) begin
                    q[i] <= d;
                end
            end
        end
    end

endmodule

// File: rtl/ctrl_seq.sv
// Control sequencer: compare-flag bank, branch decision, post-branch flush
// window and sticky halt. Optional taken-branch counter under CTRL_BRCOUNT_EN.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int INSTR_W   = INSTR_W_DEF,
    parameter int OP_W      = OP_W_DEF,
    parameter int NUM_FLAGS = 2,
    parameter int BR_DELAY  = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [INSTR_W-1:0]   Instruction,
    input  logic                 instr_valid,
    input  logic                 FLAG_IN,
    output logic                 branch_en,
    output logic                 flag_write,
    output logic                 flush,
    output logic                 halt,
    output logic [NUM_FLAGS-1:0] flags_q,
`ifdef CTRL_BRCOUNT_EN
    output logic [15:0]          br_count,
`endif
    output ctrl_state_t          dbg_state_o
);

    localparam int FSEL_W = fsel_width(NUM_FLAGS);

    logic [OP_W-1:0]          op;
    logic [FSEL_W-1:0]        fsel;
    logic [(1<<FSEL_W)-1:0]   flags_pad;
    logic                     act;
    logic                     sel_ok;
    logic                     unused_instr;
    ctrl_state_t              state_q, state_d;
    logic [1:0]               cnt_q, cnt_d;

    assign op           = Instruction[INSTR_W-1 -: OP_W];
    assign fsel         = Instruction[FSEL_W-1:0];
    assign unused_instr = ^Instruction;

    // An instruction is acted on only when instr_valid is high in RUN and
    // Reset is low; there is no back-pressure, the fetch side never stalls.
    always_comb begin
        flags_pad                  = '0;
        flags_pad[NUM_FLAGS-1:0]   = flags_q;
        act        = instr_valid && (state_q == RUN) && !Reset;
        sel_ok     = int'(fsel) < NUM_FLAGS;
        flag_write = act && sel_ok &&
                     ((op == OP_W'(opCEQ)) || (op == OP_W'(opCLT)));
        branch_en  = act && sel_ok && (op == OP_W'(opOTHER)) && flags_pad[fsel];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (act && (op == OP_W'(opHALT))) begin
                    state_d = HALT;
                end else if (branch_en && (BR_DELAY > 0)) begin
                    state_d = FLUSH;
                    cnt_d   = 2'(BR_DELAY - 1);
                end
            end
            FLUSH: begin
                if (cnt_q == 2'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign flush       = (state_q == FLUSH);
    assign halt        = (state_q == HALT);
    assign dbg_state_o = state_q;

    ctrl_flag_bank #(
        .NUM_FLAGS (NUM_FLAGS),
        .SEL_W     (FSEL_W)
    ) u_flag_bank (
        .Clk   (Clk),
        .Reset (Reset),
        .we    (flag_write),
        .sel   (fsel),
        .d     (FLAG_IN),
        .q     (flags_q)
    );

`ifdef CTRL_BRCOUNT_EN
    logic [15:0] br_count_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            br_count_q <= 16'd0;
        end else if (branch_en && (br_count_q != 16'hFFFF)) begin
            br_count_q <= br_count_q + 16'd1;
        end
    end

    assign br_count = br_count_q;
`endif

endmodule
